// File: rtl/bin_mul.sv
// bin_mul -- sequential shift-add unsigned multiplier.
//
// Multiplies two WIDTH-bit unsigned operands in WIDTH clock cycles, one
// partial product per cycle, LSB of the multiplier first. The full
// 2*WIDTH-bit product is published on P when the last step completes, and
// P holds that value until the next completion or a reset.
//
// Parameters:
//   WIDTH  operand width in bits (2..16)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (clears all state, aborts operation)
//   start  request a multiplication; only honoured while idle
//   A      unsigned multiplicand, sampled on the accepting edge
//   B      unsigned multiplier, sampled on the accepting edge
//   P      unsigned 2*WIDTH-bit product of the last completed operation
//   busy   high from the cycle after acceptance through the done cycle
//   done   one-cycle pulse in the cycle after P has been updated
//
// Build option:
//   BIN_MUL_ZERO_BYPASS_EN  when defined, a zero operand at acceptance skips
//                           the shift-add loop and completes with P=0 in the
//                           cycle after the start edge.
module bin_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_step;
  logic [CNT_W-1:0]     cnt;
  logic                 last_step;
  logic                 zero_op;

`ifdef BIN_MUL_ZERO_BYPASS_EN
  assign zero_op = (A == '0) || (B == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Accumulator value after the current step; also what P receives on the
  // final step so the last partial product is not lost.
  assign acc_step  = acc + (mplier[0] ? mcand : '0);
  assign last_step = (state == CALC) && (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = zero_op ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: operand latch, shift-add iteration and product register
  always_ff @(posedge clk) begin
    if (rst) begin
      mplier <= '0;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
      P      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mplier <= B;
            mcand  <= {{WIDTH{1'b0}}, A};
            acc    <= '0;
            cnt    <= '0;
            if (zero_op) begin
              P <= '0;
            end
          end
        end
        CALC: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt + 1'b1;
          if (last_step) begin
            P <= acc_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_mul.sv
// tb_bin_mul -- self-checking bench for bin_mul (WIDTH=4).
// Expected products come from plain integer multiplication; expected
// latencies come from the documented timing of the block.
module tb_bin_mul;

  localparam int W     = 4;
  localparam int BOUND = 4 * W + 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic [2*W-1:0]   P;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;
  int model_p  = 0;

  bin_mul #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int p;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_latency(input int a, input int b);
`ifdef BIN_MUL_ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 0;
`endif
    return W;
  endfunction

  // Waits until done is seen; n = cycles elapsed, or -1 if the bound expired.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    if (done !== 1'b1) n = -1;
  endtask

  // One complete operation; caller is positioned #1 after an edge with the
  // DUT idle.
  task automatic run_op(input int a, input int b, input string tag);
    int n;
    int exp;
    exp = a * b;
    A = W'(a);
    B = W'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    check({tag, " busy_after_start"}, int'(busy), 1);
    check({tag, " P_hold"}, int'(P), model_p);
    wait_done(n);
    check({tag, " latency"}, n, exp_latency(a, b));
    check({tag, " P"}, int'(P), exp);
    model_p = exp;
    tick();
    check({tag, " done_one_cycle"}, int'(done), 0);
    check({tag, " busy_after_done"}, int'(busy), 0);
    check({tag, " P_after_done"}, int'(P), model_p);
  endtask

  initial begin
    int n;
    int seen;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    tick();
    tick();
    check("reset P", int'(P), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    rst = 1'b0;
    tick();

    // Directed table
    vecs.push_back('{1, 0, 0});
    vecs.push_back('{7, 5, 35});
    vecs.push_back('{8, 9, 72});
    vecs.push_back('{15, 15, 225});
    vecs.push_back('{0, 0, 0});
    vecs.push_back('{15, 1, 15});
    vecs.push_back('{1, 15, 15});
    vecs.push_back('{0, 11, 0});
    vecs.push_back('{6, 10, 60});
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table_P", i), int'(P), vecs[i].p);
    end

    // Back-to-back with start held high
    A = 4'd8;
    B = 4'd9;
    start = 1'b1;
    tick();
    A = 4'd15;
    B = 4'd15;
    wait_done(n);
    check("b2b first latency", n, W);
    check("b2b first P", int'(P), 72);
    wait_done(n);
    tick();
    wait_done(n);
    check("b2b second spacing", n + 1, W + 2);
    check("b2b second P", int'(P), 225);
    start = 1'b0;
    A = '0;
    B = '0;
    tick();
    check("b2b done pulse", int'(done), 0);
    tick();
    check("b2b idle", int'(busy), 0);
    model_p = 225;

    // Start during CALC is ignored
    A = 4'd7;
    B = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 4'd3;
    B = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("ignore latency", n + 2, W);
    check("ignore P", int'(P), 35);
    model_p = 35;
    tick();
    tick();
    check("ignore no restart", int'(busy), 0);

    // Reset during CALC aborts without done
    A = 4'd15;
    B = 4'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort P", int'(P), 0);
    check("abort busy", int'(busy), 0);
    seen = int'(done);
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    check("abort no done", seen, 0);
    model_p = 0;
    run_op(3, 4, "after_abort");

    // Reset takes priority over start
    A = 4'd5;
    B = 4'd5;
    start = 1'b1;
    rst = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b0;
    check("rst_prio busy", int'(busy), 0);
    check("rst_prio P", int'(P), 0);
    model_p = 0;

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range((1 << W) - 1, 0)),
             int'($urandom_range((1 << W) - 1, 0)),
             $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_mul.md
BIN_MUL -- requirements
Module: bin_mul

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal values are 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiplication.
REQ-005 The block SHALL have port A, input, WIDTH bits: unsigned multiplicand.
REQ-006 The block SHALL have port B, input, WIDTH bits: unsigned multiplier.
REQ-007 The block SHALL have port P, output, 2*WIDTH bits: unsigned product of the last completed operation.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking that P has just been updated.

Function
REQ-010 The block SHALL use a three-state FSM with states IDLE, CALC and DONE.
REQ-011 In IDLE, start=1 at a clock edge SHALL:
- latch A and B into internal registers;
- clear the accumulator and the iteration counter;
- move the FSM to CALC.
REQ-012 In CALC, each clock edge SHALL perform one shift-add step (LSB first, multiplier register shifted right, multiplicand register shifted left, accumulator += multiplicand when the multiplier LSB is 1), for exactly WIDTH steps.
REQ-013 On the edge that completes step WIDTH, the block SHALL:
- load P with the full 2*WIDTH-bit accumulator;
- move the FSM to DONE.
REQ-014 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-015 Timing relative to the edge that samples start:
- done SHALL be high in the cycle following edge WIDTH after that edge;
- busy SHALL be high from the cycle after the start edge up to and including the DONE cycle.
REQ-016 P SHALL hold its value between operations and SHALL change only on the completion edge (or on reset).
REQ-017 The block SHALL ignore start whenever the FSM is not in IDLE; A and B SHALL be sampled only on the accepting edge.
REQ-018 The product SHALL be exact for all operand pairs; the maximum value (2^WIDTH-1)^2 SHALL fit in P with no truncation.
REQ-019 start held high continuously SHALL result in back-to-back operations, each new one accepted on the first IDLE edge.

Reset
REQ-020 When rst=1 at a clock edge, the block SHALL:
- set P, done and busy to 0;
- clear the internal operand, accumulator and counter registers;
- move the FSM to IDLE.
REQ-021 Reset SHALL take priority over start on the same edge, and a reset in mid-operation SHALL abort that operation without ever asserting done.

Configuration
REQ-022 When macro BIN_MUL_ZERO_BYPASS_EN is defined and the latched A or B is zero at acceptance, the block SHALL skip CALC and go directly from IDLE to DONE with P=0. Done SHALL be high in the cycle after the start edge.
REQ-023 When BIN_MUL_ZERO_BYPASS_EN is undefined, zero operands SHALL follow the normal WIDTH-step path with the same latency as any other operands.

Verification
REQ-024 Reset, then A=1, B=0, start pulse:
- P=0 with done after WIDTH steps;
- P=0 with done 1 cycle after start when BIN_MUL_ZERO_BYPASS_EN is defined.
REQ-025 A=7, B=5, start pulse -> P=8'b00100011 (35); done high for exactly one cycle; busy deasserts after done.
REQ-026 A=8, B=9, then A=15, B=15, issued back-to-back with start held high -> P=72, then P=225 (8'b11100001), each with its own done pulse.
REQ-027 Start A=7, B=5, then change A and B and pulse start again mid-CALC -> P=35; the second start is ignored.
REQ-028 Start A=15, B=15, assert rst on cycle 2 -> P=0, busy=0, no done pulse; the next start with A=3, B=4 yields P=12.
